uart_tx: RTL and testbench
==========================

Name: uart_tx

Overview:
UART transmitter that serialises one byte per frame onto the tx line: start bit, DATA_W data bits LSB first, optional parity, one stop bit. It is the transmit counterpart of the UART receive path. It uses the same 16-bit baud divisor `brd` so both ends agree on bit time. Bytes are loaded through a valid/ready handshake from the LSU/UART register interface.

Parameters:
DATA_W, 8, number of data bits per frame (1..8)

Ports:
clk  input  1  system clock
reset  input  1  asynchronous active-low reset
brd  input  16  baud divisor: clk cycles per bit; 0 is treated as 1
tx_data  input  DATA_W  byte to send; captured on handshake
tx_valid  input  1  producer has a byte
tx_ready  output  1  transmitter can accept a byte (IDLE only)
tx  output  1  serial line; idle high
busy  output  1  frame in progress (any state except IDLE)
done  output  1  one-cycle pulse in the last clk cycle of the stop bit
baud_tick  output  1  pulse on the last clk cycle of every bit period (for simulation)
count_bits  output  4  data bits already shifted out in the current frame (for simulation)

Behaviour:
- Reset (reset=0, asynchronous): state IDLE, tx=1, tx_ready=1, busy=0, done=0, baud_tick=0, count_bits=0, shift reg=0, baud counter=0.
- Handshake: accept when tx_valid && tx_ready at a rising edge. On accept:
  - latch tx_data into the shift reg;
  - latch brd into the internal divisor (brd changes mid-frame are ignored);
  - go to START.
- tx_valid while busy: ignored, not queued.
- Baud counter: counts 0..div-1 and restarts from 0 on each state entry. baud_tick=1 when counter==div-1. div = latched brd, or 1 if brd==0. Each bit lasts exactly div clk cycles.
- States, with tx driven registered from state:
  - IDLE: tx=1.
  - START: tx=0. On baud_tick go to DATA.
  - DATA: tx=shreg[0]. On baud_tick shift right and increment count_bits. After the DATA_W-th bit go to PARITY if compiled in, else STOP.
  - PARITY: see Optional Feature.
  - STOP: tx=1. On baud_tick assert done and go to IDLE.
- Timing, with the accept edge at cycle T:
  - tx falls at T+1.
  - Without parity, the frame occupies T+1..T+(DATA_W+2)*div, and done is high in cycle T+(DATA_W+2)*div.
- Back-to-back frames: tx_ready is 1 again the cycle after done. The minimum gap is one extra idle-high cycle beyond the stop bit.
- count_bits clears to 0 on entry to START and holds its value through PARITY and STOP.
- busy = (state != IDLE). tx_ready = (state == IDLE). Both are combinational from state.
- Reset asserted mid-frame: immediate return to reset values; tx goes high asynchronously; no done pulse.
- div=1 (brd=0 or 1): one cycle per bit, and baud_tick is high every busy cycle.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined:
  - Adds state PARITY between DATA and STOP, lasting div cycles.
  - tx = even parity (XOR of the latched data bits) in that bit period.
  - The frame becomes DATA_W+3 bit periods long.
- Undefined: the PARITY state and its XOR logic do not exist; the frame is DATA_W+2 bit periods.

Test Plan:
- Reset check: hold reset=0 for 3 cycles, then release -> tx=1, tx_ready=1, busy=0, done=0, count_bits=0.
- Byte 0xA5, brd=4, no parity: accept at T -> tx sequence 0,1,0,1,0,0,1,0,1,1, each bit 4 cycles, from T+1; done only at T+40; tx_ready=1 at T+41.
- Same stimulus with UART_TX_PARITY_EN -> parity bit 0 occupies T+37..T+40, stop bit T+41..T+44, done at T+44. With 0x07 the parity bit is 1.
- tx_valid held high with 0x55 then 0x3C, brd=2 -> two frames; second start bit begins 1 cycle after the first frame's done; the tx_valid pulse mid-frame is not accepted.
- brd=0 and brd=1 -> 1 cycle per bit, 10-cycle frame, baud_tick high every busy cycle. Changing brd from 4 to 8 mid-frame leaves bit length at 4.
- Reset pulled low at T+15 of a brd=4 frame -> tx=1 immediately, busy=0, no done pulse; next accepted byte transmits correctly.

Source files
------------

// File: rtl/uart_tx.sv
// UART transmitter: start bit, DATA_W data bits LSB first, optional even parity, one stop bit.
// Define UART_TX_PARITY_EN to compile in the parity bit period.
//
// state    | meaning
// ST_IDLE  | line high, ready for a byte
// ST_START | start bit (tx=0)
// ST_DATA  | data bits, shreg[0] on the line
// ST_PARITY| even parity of latched byte (UART_TX_PARITY_EN only)
// ST_STOP  | stop bit (tx=1), done on its last cycle
module uart_tx #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [15:0]       brd,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              tx,
  output logic              busy,
  output logic              done,
  output logic              baud_tick,
  output logic [3:0]        count_bits
);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP} state_t;
`else
  typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP} state_t;
`endif

  state_t            state;
  logic [15:0]       div_q;
  logic [15:0]       cnt_q;
  logic [DATA_W-1:0] shreg;
  logic [DATA_W-1:0] shreg_nxt;
  logic              last_bit;
`ifdef UART_TX_PARITY_EN
  logic              parity_q;
`endif

  assign shreg_nxt = shreg >> 1;
  assign last_bit  = (count_bits == 4'(DATA_W - 1));
  assign busy      = (state != ST_IDLE);
  assign tx_ready  = (state == ST_IDLE);
  // div_q is never 0 once a frame runs, so div_q-1 cannot wrap while busy
  assign baud_tick = busy && (cnt_q == div_q - 16'd1);
  assign done      = (state == ST_STOP) && baud_tick;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ST_IDLE;
      tx         <= 1'b1;
      div_q      <= 16'd0;
      cnt_q      <= 16'd0;
      shreg      <= '0;
      count_bits <= 4'd0;
`ifdef UART_TX_PARITY_EN
      parity_q   <= 1'b0;
`endif
    end else begin
      if (busy) begin
        cnt_q <= baud_tick ? 16'd0 : cnt_q + 16'd1;
      end
      case (state)
        ST_IDLE: begin
          cnt_q <= 16'd0;
          if (tx_valid) begin
            shreg      <= tx_data;
            div_q      <= (brd == 16'd0) ? 16'd1 : brd;
            count_bits <= 4'd0;
            tx         <= 1'b0;
            state      <= ST_START;
`ifdef UART_TX_PARITY_EN
            parity_q   <= ^tx_data;
`endif
          end
        end
        ST_START: begin
          if (baud_tick) begin
            tx    <= shreg[0];
            state <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (baud_tick) begin
            shreg      <= shreg_nxt;
            count_bits <= count_bits + 4'd1;
            if (last_bit) begin
`ifdef UART_TX_PARITY_EN
              tx    <= parity_q;
              state <= ST_PARITY;
`else
              tx    <= 1'b1;
              state <= ST_STOP;
`endif
            end else begin
              tx <= shreg_nxt[0];
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        ST_PARITY: begin
          if (baud_tick) begin
            tx    <= 1'b1;
            state <= ST_STOP;
          end
        end
`endif
        ST_STOP: begin
          if (baud_tick) begin
            tx    <= 1'b1;
            state <= ST_IDLE;
          end
        end
        default: begin
          tx    <= 1'b1;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: table of frames plus back-to-back and mid-frame reset sequences.
module tb_uart_tx;
  localparam int DW = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] brd = 16'd4;
  logic [7:0]  tx_data = 8'h00;
  logic        tx_valid = 1'b0;
  logic        tx_ready, tx, busy, done, baud_tick;
  logic [3:0]  count_bits;

  int checks = 0;
  int failures = 0;

  uart_tx #(.DATA_W(DW)) dut (
    .clk(clk), .reset(reset), .brd(brd), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .tx(tx), .busy(busy), .done(done), .baud_tick(baud_tick),
    .count_bits(count_bits)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  data;
    logic [15:0] brd;
    int          div;
    logic        par;
    bit          change_brd;
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Called at a negedge with the DUT idle; returns at the negedge of the first idle cycle after the frame.
  task automatic send_frame(input logic [7:0] data, input logic [15:0] b, input int div,
                            input logic par, input bit keep_valid, input logic [7:0] next_data,
                            input bit change_brd);
    int nb, last, bi, exp_cb;
    logic exp_tx, exp_tick, exp_done;
    nb = DW + 2;
`ifdef UART_TX_PARITY_EN
    nb = nb + 1;
`endif
    last = nb * div;
    tx_data  = data;
    brd      = b;
    tx_valid = 1'b1;
    chk("ready_before_accept", {31'd0, tx_ready}, 32'd1);
    @(negedge clk);
    if (keep_valid) tx_data = next_data;
    else tx_valid = 1'b0;
    for (int c = 1; c <= last; c++) begin
      bi = (c - 1) / div;
      if (bi == 0) exp_tx = 1'b0;
      else if (bi <= DW) exp_tx = data[bi-1];
      else if (bi == DW + 1 && nb == DW + 3) exp_tx = par;
      else exp_tx = 1'b1;
      exp_cb   = (bi == 0) ? 0 : ((bi - 1 > DW) ? DW : bi - 1);
      exp_tick = (((c - 1) % div) == div - 1);
      exp_done = (c == last);
      if (change_brd && c == 2) brd = 16'd8;
      chk($sformatf("frame d=%0h c=%0d {tx,busy,rdy,done,tick}", data, c),
          {27'd0, tx, busy, tx_ready, done, baud_tick},
          {27'd0, exp_tx, 1'b1, 1'b0, exp_done, exp_tick});
      chk($sformatf("frame d=%0h c=%0d count_bits", data, c), {28'd0, count_bits}, exp_cb);
      @(negedge clk);
    end
    chk($sformatf("idle after d=%0h {tx,busy,rdy,done}", data),
        {28'd0, tx, busy, tx_ready, done}, 32'b1010);
  endtask

  initial begin
    vecs[0] = '{8'hA5, 16'd4, 4, 1'b0, 1'b0};
    vecs[1] = '{8'h07, 16'd4, 4, 1'b1, 1'b0};
    vecs[2] = '{8'h3C, 16'd1, 1, 1'b0, 1'b0};
    vecs[3] = '{8'hFF, 16'd0, 1, 1'b0, 1'b0};
    vecs[4] = '{8'h81, 16'd4, 4, 1'b0, 1'b1};
    vecs[5] = '{8'h01, 16'd3, 3, 1'b1, 1'b0};

    repeat (3) @(negedge clk);
    chk("reset {tx,rdy,busy,done,tick}", {27'd0, tx, tx_ready, busy, done, baud_tick}, 32'b11000);
    chk("reset count_bits", {28'd0, count_bits}, 32'd0);
    reset = 1'b1;
    @(negedge clk);
    chk("post_reset {tx,rdy,busy}", {29'd0, tx, tx_ready, busy}, 32'b110);

    for (int i = 0; i < 6; i++) begin
      send_frame(vecs[i].data, vecs[i].brd, vecs[i].div, vecs[i].par, 1'b0, 8'h00,
                 vecs[i].change_brd);
      brd = 16'd4;
    end

    // tx_valid held through both frames: the mid-frame data change must not be taken early
    send_frame(8'h55, 16'd2, 2, 1'b0, 1'b1, 8'h3C, 1'b0);
    send_frame(8'h3C, 16'd2, 2, 1'b0, 1'b0, 8'h00, 1'b0);

    // reset in the middle of a brd=4 frame
    tx_data  = 8'hA5;
    brd      = 16'd4;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    repeat (14) @(negedge clk);
    chk("midframe busy before reset", {31'd0, busy}, 32'd1);
    reset = 1'b0;
    #1;
    chk("async reset {tx,busy,rdy,done}", {28'd0, tx, busy, tx_ready, done}, 32'b1010);
    chk("async reset count_bits", {28'd0, count_bits}, 32'd0);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk("in reset done/tx", {30'd0, done, tx}, 32'b01);
    end
    reset = 1'b1;
    @(negedge clk);
    send_frame(8'hC3, 16'd4, 4, 1'b0, 1'b0, 8'h00, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
